// File: rtl/sd_11011.sv
`default_nettype none
// ============================================================================
//  Module      : sd_11011
//  Description : Serial detector for the bit sequence 1-1-0-1-1. Mealy FSM
//                with non-overlapping detection: once a match completes, the
//                search restarts from the idle state and no bit of the match
//                is reused. The detect strobe is combinational and asserts in
//                the same cycle that the fifth bit is on the input.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_11011 (
  input  logic clk,
  input  logic rst,     // synchronous, active-low
  input  logic signal,
  output logic out
);

  // Binary-encoded states, each named after the longest useful prefix held.
  typedef enum logic [2:0] {
    S0 = 3'd0,  // no useful prefix
    S1 = 3'd1,  // "1"
    S2 = 3'd2,  // "11"
    S3 = 3'd3,  // "110"
    S4 = 3'd4   // "1101"
  } state_t;

  state_t state_q;
  state_t state_d;

  // State register: a reset edge discards any partial prefix.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and Mealy detect strobe.
  always_comb begin
    state_d = S0;
    out     = 1'b0;
    case (state_q)
      S0: state_d = signal ? S1 : S0;
      S1: state_d = signal ? S2 : S0;
      // A run of 1s keeps the "11" prefix alive.
      S2: state_d = signal ? S2 : S3;
      S3: state_d = signal ? S4 : S0;
      // Completed match returns to S0 so the trailing "11" is not reused.
      S4: begin
        state_d = S0;
        out     = rst & signal;
      end
      // Unused encodings recover to idle with the strobe held low.
      default: begin
        state_d = S0;
        out     = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_11011.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_11011
//  Description : Self-checking bench for sd_11011. A reference model of the
//                non-overlapping 11011 search pushes the expected strobe for
//                every applied bit into a scoreboard queue; each scenario
//                pops and compares it against the DUT output mid-cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_11011;

  logic clk;
  logic rst;
  logic signal;
  logic out;

  int passed;
  int total;

  // Scoreboard of expected strobe values, one per applied bit.
  logic exp_q[$];

  // Reference model: bits seen since the last restart (reset or detection).
  logic [3:0] m_hist;
  int         m_cnt;
  logic       last_b;
  logic       last_r;
  logic       last_e;

  sd_11011 dut (
    .clk    (clk),
    .rst    (rst),
    .signal (signal),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one bit/reset value after the falling edge and predict the strobe.
  task automatic drive_bit(input logic b, input logic r);
    logic e;
    @(negedge clk);
    signal = b;
    rst    = r;
    e = r && (m_cnt >= 4) && ({m_hist, b} == 5'b11011);
    exp_q.push_back(e);
    last_b = b;
    last_r = r;
    last_e = e;
  endtask

  // Let the rising edge happen and move the reference model along.
  task automatic advance();
    @(posedge clk);
    if (!last_r || last_e) begin
      m_hist = 4'b0000;
      m_cnt  = 0;
    end else begin
      m_hist = {m_hist[2:0], last_b};
      if (m_cnt < 4) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic test_reset();
    logic e;
    // Before any clock edge, rst=0 must hold the strobe low.
    #1;
    total++;
    if (out !== 1'b0)
      $display("FAIL reset_pre_edge: out=%b required=0", out);
    else
      passed++;
    for (int i = 0; i < 2; i++) begin
      drive_bit(1'b1, 1'b0);
      #2;
      e = exp_q.pop_front();
      total++;
      if (out !== e)
        $display("FAIL reset_hold[%0d]: out=%b required=%b", i, out, e);
      else
        passed++;
      advance();
    end
  endtask

  // Shared body shape for sequence scenarios; each keeps its own compares.
  task automatic test_basic();
    logic [15:0] seq = 16'b0011011;
    logic [15:0] rv  = 16'b0111111;
    int n = 7; int pulses = 0; int pos = -1; logic e;
    for (int i = 0; i < n; i++) begin
      drive_bit(seq[n-1-i], rv[n-1-i]);
      #2;
      e = exp_q.pop_front();
      total++;
      if (out !== e) $display("FAIL basic[%0d]: out=%b required=%b", i, out, e);
      else passed++;
      if (out === 1'b1) begin pulses++; pos = i; end
      advance();
    end
    total++;
    if (pulses !== 1 || pos !== 6)
      $display("FAIL basic_pulse: pulses=%0d pos=%0d required pulses=1 pos=6", pulses, pos);
    else passed++;
  endtask

  task automatic test_reset_hold();
    logic [15:0] seq = 16'b1111011;
    logic [15:0] rv  = 16'b0011111;
    int n = 7; int pulses = 0; int pos = -1; logic e;
    for (int i = 0; i < n; i++) begin
      drive_bit(seq[n-1-i], rv[n-1-i]);
      #2;
      e = exp_q.pop_front();
      total++;
      if (out !== e) $display("FAIL reset_then_match[%0d]: out=%b required=%b", i, out, e);
      else passed++;
      if (out === 1'b1) begin pulses++; pos = i; end
      advance();
    end
    total++;
    if (pulses !== 1 || pos !== 6)
      $display("FAIL reset_then_match_pulse: pulses=%0d pos=%0d required pulses=1 pos=6", pulses, pos);
    else passed++;
  endtask

  task automatic test_no_overlap();
    logic [15:0] seq = 16'b011011011;
    logic [15:0] rv  = 16'b011111111;
    int n = 9; int pulses = 0; int pos = -1; logic e;
    for (int i = 0; i < n; i++) begin
      drive_bit(seq[n-1-i], rv[n-1-i]);
      #2;
      e = exp_q.pop_front();
      total++;
      if (out !== e) $display("FAIL no_overlap[%0d]: out=%b required=%b", i, out, e);
      else passed++;
      if (out === 1'b1) begin pulses++; pos = i; end
      advance();
    end
    total++;
    if (pulses !== 1 || pos !== 5)
      $display("FAIL no_overlap_pulse: pulses=%0d pos=%0d required pulses=1 pos=5", pulses, pos);
    else passed++;
  endtask

  task automatic test_ones_run();
    logic [15:0] seq = 16'b01111011;
    logic [15:0] rv  = 16'b01111111;
    int n = 8; int pulses = 0; int pos = -1; logic e;
    for (int i = 0; i < n; i++) begin
      drive_bit(seq[n-1-i], rv[n-1-i]);
      #2;
      e = exp_q.pop_front();
      total++;
      if (out !== e) $display("FAIL ones_run[%0d]: out=%b required=%b", i, out, e);
      else passed++;
      if (out === 1'b1) begin pulses++; pos = i; end
      advance();
    end
    total++;
    if (pulses !== 1 || pos !== 7)
      $display("FAIL ones_run_pulse: pulses=%0d pos=%0d required pulses=1 pos=7", pulses, pos);
    else passed++;
  endtask

  task automatic test_mid_reset();
    logic [15:0] seq = 16'b0110111;
    logic [15:0] rv  = 16'b0111101;
    int n = 7; int pulses = 0; int pos = -1; logic e;
    for (int i = 0; i < n; i++) begin
      drive_bit(seq[n-1-i], rv[n-1-i]);
      #2;
      e = exp_q.pop_front();
      total++;
      if (out !== e) $display("FAIL mid_reset[%0d]: out=%b required=%b", i, out, e);
      else passed++;
      if (out === 1'b1) begin pulses++; pos = i; end
      advance();
    end
    total++;
    if (pulses !== 0)
      $display("FAIL mid_reset_pulse: pulses=%0d pos=%0d required pulses=0", pulses, pos);
    else passed++;
  endtask

  task automatic test_false_start();
    logic [15:0] seq = 16'b01101011011;
    logic [15:0] rv  = 16'b01111111111;
    int n = 11; int pulses = 0; int pos = -1; logic e;
    for (int i = 0; i < n; i++) begin
      drive_bit(seq[n-1-i], rv[n-1-i]);
      #2;
      e = exp_q.pop_front();
      total++;
      if (out !== e) $display("FAIL false_start[%0d]: out=%b required=%b", i, out, e);
      else passed++;
      if (out === 1'b1) begin pulses++; pos = i; end
      advance();
    end
    total++;
    if (pulses !== 1 || pos !== 10)
      $display("FAIL false_start_pulse: pulses=%0d pos=%0d required pulses=1 pos=10", pulses, pos);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq = 16'b01101111011;
    logic [15:0] rv  = 16'b01111111111;
    int n = 11; int pulses = 0; int pos = -1; logic e;
    for (int i = 0; i < n; i++) begin
      drive_bit(seq[n-1-i], rv[n-1-i]);
      #2;
      e = exp_q.pop_front();
      total++;
      if (out !== e) $display("FAIL back_to_back[%0d]: out=%b required=%b", i, out, e);
      else passed++;
      if (out === 1'b1) begin pulses++; pos = i; end
      advance();
    end
    total++;
    if (pulses !== 2 || pos !== 10)
      $display("FAIL back_to_back_pulse: pulses=%0d pos=%0d required pulses=2 pos=10", pulses, pos);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    m_hist = 4'b0000;
    m_cnt  = 0;
    last_b = 1'b0;
    last_r = 1'b0;
    last_e = 1'b0;
    rst    = 1'b0;
    signal = 1'b1;

    test_reset();
    test_basic();
    test_reset_hold();
    test_no_overlap();
    test_ones_run();
    test_mid_reset();
    test_false_start();
    test_back_to_back();

    total++;
    if (exp_q.size() !== 0)
      $display("FAIL scoreboard_drain: left=%0d required=0", exp_q.size());
    else
      passed++;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
